// File: rtl/mem_responder.sv
// mem_responder: multi-cycle unified instruction/data memory with a
// programmable wait-state latency and a one-cycle MemRdy completion pulse.
// Optional feature macro: MEM_ALIGN_CHECK_EN. When it is defined, a request
// whose byte address is not word aligned performs no access and completes
// with Err. When it is undefined, Addr[1:0] is ignored.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2   // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        MemRdy,
  output logic        Busy,
  output logic        Err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic                wr_q;
  logic                bad_q;
  logic [31:0]         rdata_q;
  logic                rdy_q;
  logic                busy_q;
  logic                err_q;
  logic [31:0]         mem_q [2**ADDR_W];

  logic                misalign;
  logic                access_now;
  logic                mem_we;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (Addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Upper address bits wrap the array; the byte offset only matters when the
  // alignment check is built in.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Addr[31:ADDR_W+2], Addr[1:0]};

  // The access happens on the edge that leaves WAIT with the counter at zero.
  assign access_now = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we     = access_now && wr_q && !bad_q && !rst;

  // Request FSM: capture, count down wait states, complete with a pulse.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, exactly like the flops they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      rdata_q <= 32'd0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b0;
          err_q <= 1'b0;
          if (MemRd || MemWr) begin
            idx_q   <= Addr[ADDR_W+1:2];
            wdata_q <= WrData;
            wr_q    <= MemWr;
            bad_q   <= (MemRd && MemWr) || misalign;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rdy_q   <= 1'b1;
            err_q   <= bad_q;
            state_q <= S_DONE;
            if (!wr_q && !bad_q) rdata_q <= mem_q[idx_q];
          end
        end
        S_DONE: begin
          rdy_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; clearing it would turn a RAM into a huge
  // bank of resettable flops, and its contents are defined by writes anyway.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign RdData = rdata_q;
  assign MemRdy = rdy_q;
  assign Busy   = busy_q;
  assign Err    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (ADDR_W=8, LATENCY=2).
module tb_mem_responder;

  localparam int ADDR_W  = 8;
  localparam int LATENCY = 2;

  logic        clk;
  logic        rst;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        MemRdy;
  logic        Busy;
  logic        Err;

  int errors = 0;
  int checks = 0;

  mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk    (clk),
    .rst    (rst),
    .MemRd  (MemRd),
    .MemWr  (MemWr),
    .Addr   (Addr),
    .WrData (WrData),
    .RdData (RdData),
    .MemRdy (MemRdy),
    .Busy   (Busy),
    .Err    (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, drop the strobes right after the sample edge and
  // scramble Addr/WrData, then verify latency, Busy, Err and pulse width.
  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err);
    int lat;
    @(negedge clk);
    MemRd = rd; MemWr = wr; Addr = a; WrData = d;
    @(posedge clk); #1;
    MemRd = 1'b0; MemWr = 1'b0; Addr = $urandom; WrData = $urandom;
    check({tag, " busy_after_sample"}, 32'(Busy), 32'd1);
    lat = 0;
    while (!MemRdy && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(LATENCY));
    check({tag, " err"}, 32'(Err), 32'(exp_err));
    @(posedge clk); #1;
    check({tag, " rdy_drop_busy_drop"}, {30'd0, MemRdy, Busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    int first_edge;
    int last_edge;
    int gap_bad;

    MemRd = 1'b0; MemWr = 1'b0; Addr = 32'd0; WrData = 32'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: all outputs low for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_flags", {29'd0, MemRdy, Busy, Err}, 32'd0);
      check("idle_rddata", RdData, 32'd0);
    end

    // Write then read back, RdData untouched by the write and held afterwards.
    do_req("wr_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    check("rddata_after_write", RdData, 32'd0);
    do_req("rd_10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("rd_10_data", RdData, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1 check("rd_10_held", RdData, 32'hDEADBEEF);

    // Wrap-around: 0x400 aliases word 0 when ADDR_W=8.
    do_req("wr_000", 1'b0, 1'b1, 32'h000, 32'h11111111, 1'b0);
    do_req("wr_400", 1'b0, 1'b1, 32'h400, 32'h22222222, 1'b0);
    do_req("rd_000", 1'b1, 1'b0, 32'h000, 32'h0, 1'b0);
    check("wrap_data", RdData, 32'h22222222);

    // Simultaneous read and write: error, no array access.
    do_req("rdwr_both", 1'b1, 1'b1, 32'h10, 32'h55555555, 1'b1);
    check("both_rddata_kept", RdData, 32'h22222222);
    do_req("rd_10_after_both", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("both_mem_kept", RdData, 32'hDEADBEEF);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned requests complete with Err and touch nothing.
    do_req("wr_misaligned", 1'b0, 1'b1, 32'h11, 32'h99999999, 1'b1);
    do_req("rd_misaligned", 1'b1, 1'b0, 32'h13, 32'h0, 1'b1);
    check("misaligned_rddata_kept", RdData, 32'hDEADBEEF);
    do_req("rd_10_after_misaligned", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("misaligned_mem_kept", RdData, 32'hDEADBEEF);
`else
    // Byte offset ignored: 0x12 and 0x13 both address word 4.
    do_req("wr_12", 1'b0, 1'b1, 32'h12, 32'h12345678, 1'b0);
    do_req("rd_13", 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    check("offset_ignored_data", RdData, 32'h12345678);
`endif

    // Strobe held for 12 edges: sampled at edges 0, 4, 8 only.
    @(negedge clk);
    MemRd = 1'b1; Addr = 32'h0;
    pulses = 0; first_edge = -1; last_edge = -1; gap_bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 11) MemRd = 1'b0;
      if (MemRdy) begin
        if (first_edge < 0) first_edge = i;
        else if (i - last_edge != LATENCY + 2) gap_bad++;
        last_edge = i;
        pulses++;
      end
    end
    check("held_pulse_count", 32'(pulses), 32'd3);
    check("held_first_pulse_edge", 32'(first_edge), 32'(LATENCY));
    check("held_pulse_spacing_bad", 32'(gap_bad), 32'd0);
    check("held_rddata", RdData, 32'h22222222);

    // Reset during the WAIT of a write aborts it.
    do_req("wr_20_prior", 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0);
    @(negedge clk);
    MemWr = 1'b1; Addr = 32'h20; WrData = 32'hCAFEF00D;
    @(posedge clk); #1;
    MemWr = 1'b0;
    check("abort_busy_in_wait", 32'(Busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_idle_after_rst", {29'd0, MemRdy, Busy, Err}, 32'd0);
    check("abort_rddata_reset", RdData, 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (MemRdy) pulses++;
    end
    check("abort_no_rdy", 32'(pulses), 32'd0);
    do_req("rd_20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("abort_mem_kept", RdData, 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
